rotation_decoder: RTL and testbench
===================================

Name: rotation_decoder

Overview:
- Receive-side counterpart of the timed left/right LED barrel-shift display.
- Watches a W-bit rotated pattern bus, sampled every `dat_valid` cycle, and compares it against the known unrotated reference pattern.
- Recovers the rotation direction and current rotation amount, and declares lock once successive steps are consistent.
- Sits on the LED/pattern bus downstream of the shifter; used for self-check and for status readback.

Parameters:
- W, 8, pattern width; must be a power of two, at least 2.
- LOCK_CNT, 3, consecutive consistent steps required to enter LOCKED.
- MISS_CNT, 2, consecutive bad steps in LOCKED before lock is dropped.
- TIMEOUT_CYC, 200000000, cycles without a step before lock is dropped (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ref_in  in  W  unrotated reference pattern; must be held stable during operation.
- dat_in  in  W  observed rotated pattern.
- dat_valid  in  1  dat_in is sampled this cycle; may be held high continuously.
- dir_out  out  1  decoded direction: 0 = left, 1 = right.
- amt_out  out  $clog2(W)  rotation amount, expressed in the decoded direction.
- locked  out  1  high while in LOCKED.
- step_pulse  out  1  one-cycle pulse on each accepted step.
- err  out  1  one-cycle pulse on each bad step while LOCKED.
- sym  out  1  ref_in is rotationally symmetric (several rotations match), so it cannot be decoded.

Behaviour:
- Reset: all outputs and state are 0; FSM enters IDLE; `prev_k`, `run_cnt` and `miss_cnt` are cleared. Reset is asynchronous, including mid-operation.
- Match, combinational:
  - k = smallest value in 0..W-1 with rotl(ref_in,k) == dat_in.
  - `hit` = at least one k matches.
  - `uniq` = exactly one k matches.
  - `sym` is registered each cycle as "more than one k matches rotl(ref_in,k) == ref_in".
- Step classification on a `dat_valid` cycle, with d = (k - prev_k) mod W:
  - d == 0: hold. Ignored; no counters change.
  - d == 1: left step.
  - d == W-1: right step.
  - otherwise, or !hit or !uniq: bad.
  - For W == 2, d == 1 is treated as the current direction candidate (left if none yet).
- IDLE: on valid with hit && uniq, store prev_k = k and move to ACQ with run_cnt = 0 and the direction candidate unset.
- ACQ:
  - Left or right step: if no candidate yet, or it agrees with the candidate, set the candidate, increment run_cnt, update prev_k and pulse step_pulse.
  - A step opposite to the candidate, or a bad sample that still has hit && uniq: restart ACQ with run_cnt = 0 and prev_k = k.
  - !hit or !uniq: go to IDLE.
  - When run_cnt reaches LOCK_CNT, go to LOCKED and latch dir_out.
- LOCKED:
  - A step in dir_out: update prev_k, pulse step_pulse, clear miss_cnt.
  - Any other non-hold sample: pulse err and increment miss_cnt; prev_k is unchanged.
  - When miss_cnt reaches MISS_CNT, go to IDLE and clear locked.
- amt_out: k when dir_out = 0; (W - k) mod W when dir_out = 1. Updated on every accepted step.
- Wrap-around is inherent in the modulo arithmetic: 7 -> 0 is a valid left step, 0 -> 7 a valid right step.
- Latency: all outputs are registered and valid one cycle after the qualifying `dat_valid` edge.
- ref_in change mid-run: no special handling; it is covered by the miss and IDLE paths.
- A symmetric ref_in can never lock, because !uniq always returns the FSM to IDLE.

Optional Feature:
- Macro: ROTATION_DECODER_TIMEOUT_EN.
- Defined: a step-timeout counter, wide enough to hold TIMEOUT_CYC, runs in LOCKED and clears on every step_pulse. On reaching TIMEOUT_CYC-1 it forces IDLE, clears locked and pulses err.
- Undefined: the counter is absent; LOCKED is held indefinitely while the pattern is static.

Decomposition:
- Package rotation_decoder_pkg holds:
  - enum state_t {IDLE, ACQ, LOCKED};
  - typedef dir_t (DIR_LEFT = 0, DIR_RIGHT = 1);
  - a rotl function.
- Sub-module rotation_matcher: combinational, producing k, hit and uniq from ref_in and dat_in, plus its symmetry check.
- FSM, counters and output registers live in the top level.

Test Plan:
- Left acquire: ref_in=0x01; dat_in 0x01, 0x02, 0x04, 0x08, each held 5 cycles with dat_valid=1 -> step_pulse ×3, locked=1 one cycle after 0x08 is first sampled, dir_out=0, amt_out=3, err never asserted.
- Right acquire: ref_in=0x03; dat_in 0x03, 0x81, 0xC0, 0x60 -> locked=1, dir_out=1, amt_out=3.
- Wrap: locked left with ref_in=0x01 at 0x80 (amt_out=7), next 0x01 -> amt_out=0, step_pulse=1, locked stays 1.
- Miss: locked left at 0x02; inject 0x10, then 0x40 -> err pulses twice, locked=0 in the cycle after the second, FSM in IDLE; amt_out holds its last value.
- Symmetric: ref_in=0x55; dat_in alternates 0x55/0xAA -> sym=1, locked stays 0, no step_pulse.
- Reset and timeout:
  - Assert reset_n=0 mid-LOCKED -> all outputs 0 immediately, with no clock edge required.
  - With ROTATION_DECODER_TIMEOUT_EN and TIMEOUT_CYC=100: lock, then hold dat_in for 100 cycles -> err pulse, locked=0.

Source files
------------

// File: rtl/rotation_decoder_pkg.sv
// rotation_decoder_pkg: shared FSM/direction types and the rotate-left helper.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
//
// Contents: state_t (IDLE/ACQ/LOCKED), dir_t (DIR_LEFT/DIR_RIGHT), rotl().
package rotation_decoder_pkg;

  // rotl() works on a fixed-width container so one function serves every
  // pattern width up to MAX_W; callers zero-extend and slice back.
  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Rotate the low w bits of v left by k. w must be a power of two so the
  // modulo reduces to a mask; bits at and above w are returned as zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                            input int unsigned    w,
                                            input int unsigned    k);
    logic [MAX_W-1:0] r;
    logic [IDX_W-1:0] idx;
    r   = '0;
    idx = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        idx    = IDX_W'((i + k) & (w - 1));
        r[idx] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rotation_matcher.sv
// rotation_matcher: finds which rotation of the reference pattern equals the observed pattern.
// Latency: purely combinational, no registers.
// Backpressure: none; evaluates every cycle regardless of valid.
//
// Ports:
//   ref_i  [W]     unrotated reference pattern
//   dat_i  [W]     observed pattern
//   k_o    [KW]    smallest k with rotl(ref_i,k) == dat_i (0 when no hit)
//   hit_o          at least one rotation matches
//   uniq_o         exactly one rotation matches
//   sym_o          reference matches itself under more than one rotation
module rotation_matcher
  import rotation_decoder_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = $clog2(W)
) (
  input  logic [W-1:0]  ref_i,
  input  logic [W-1:0]  dat_i,
  output logic [KW-1:0] k_o,
  output logic          hit_o,
  output logic          uniq_o,
  output logic          sym_o
);

  logic [W-1:0]     match_vec;
  logic [W-1:0]     self_vec;
  logic [MAX_W-1:0] rot;
  int unsigned      n_match;
  int unsigned      n_self;

  always_comb begin
    match_vec = '0;
    self_vec  = '0;
    rot       = '0;
    k_o       = '0;
    n_match   = 0;
    n_self    = 0;
    // Walk from the top so the last assignment to k_o is the smallest match.
    for (int r = W - 1; r >= 0; r--) begin
      rot          = rotl(MAX_W'(ref_i), W, r);
      match_vec[r] = (rot[W-1:0] == dat_i);
      self_vec[r]  = (rot[W-1:0] == ref_i);
      if (match_vec[r]) begin
        k_o = KW'(r);
      end
    end
    for (int r = 0; r < W; r++) begin
      if (match_vec[r]) n_match++;
      if (self_vec[r])  n_self++;
    end
  end

  assign hit_o  = (n_match != 0);
  assign uniq_o = (n_match == 1);
  // k = 0 always self-matches, so any second match means the pattern is
  // rotationally symmetric and the rotation amount is ambiguous.
  assign sym_o  = (n_self > 1);

endmodule

// File: rtl/rotation_decoder.sv
// rotation_decoder: recovers direction/amount of a barrel-rotated LED pattern and locks on consistent steps.
// Latency: every output registered, valid one cycle after the qualifying dat_valid edge.
// Backpressure: none; dat_valid may be held high, each valid cycle is consumed immediately.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   ref_in  [W]       unrotated reference (held stable)
//   dat_in  [W]       observed rotated pattern, sampled when dat_valid
//   dir_out           decoded direction (0 left, 1 right)
//   amt_out [log2 W]  rotation amount in the decoded direction
//   locked            high while in LOCKED
//   step_pulse, err   one-cycle pulses: accepted step / bad step while locked
//   sym               ref_in is rotationally symmetric (undecodable)
// Build option: ROTATION_DECODER_TIMEOUT_EN adds a step timeout that drops lock
// after TIMEOUT_CYC cycles in LOCKED without a step.
module rotation_decoder
  import rotation_decoder_pkg::*;
#(
  parameter int W           = 8,
  parameter int LOCK_CNT    = 3,
  parameter int MISS_CNT    = 2,
  parameter int TIMEOUT_CYC = 200000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [W-1:0]         ref_in,
  input  logic [W-1:0]         dat_in,
  input  logic                 dat_valid,
  output logic                 dir_out,
  output logic [$clog2(W)-1:0] amt_out,
  output logic                 locked,
  output logic                 step_pulse,
  output logic                 err,
  output logic                 sym
);

  localparam int KW     = $clog2(W);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_CNT + 1);

  if ((W < 2) || ((W & (W - 1)) != 0) || (W > MAX_W) || (TIMEOUT_CYC < 2)) begin : g_bad_cfg
    $error("rotation_decoder: W must be a power of two in 2..64 and TIMEOUT_CYC >= 2");
  end

  // Matcher results
  logic [KW-1:0] k;
  logic          hit;
  logic          uniq;
  logic          sym_c;

  rotation_matcher #(.W(W), .KW(KW)) u_matcher (
    .ref_i  (ref_in),
    .dat_i  (dat_in),
    .k_o    (k),
    .hit_o  (hit),
    .uniq_o (uniq),
    .sym_o  (sym_c)
  );

  // State
  state_t            state_q,    state_d;
  logic [KW-1:0]     prev_k_q,   prev_k_d;
  logic [RUN_W-1:0]  run_cnt_q,  run_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              cand_vld_q, cand_vld_d;
  dir_t              cand_dir_q, cand_dir_d;
  dir_t              dir_q,      dir_d;
  logic [KW-1:0]     amt_q,      amt_d;
  logic              locked_q,   locked_d;
  logic              step_q,     step_d;
  logic              err_q,      err_d;
  logic              sym_q;

`ifdef ROTATION_DECODER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Step classification. d wraps naturally in KW bits because W is 2**KW.
  logic [KW-1:0] d;
  logic          good;
  logic          hold;
  logic          step_vld;
  logic          ref_dir_vld;
  dir_t          ref_dir;
  dir_t          step_dir;

  assign d    = k - prev_k_q;
  assign good = hit && uniq;
  assign hold = good && (d == '0);

  // Direction the current step is judged against: the acquisition candidate
  // in ACQ, the latched direction in LOCKED.
  assign ref_dir_vld = (state_q == LOCKED) ? 1'b1  : cand_vld_q;
  assign ref_dir     = (state_q == LOCKED) ? dir_q : cand_dir_q;

  always_comb begin
    step_vld = good && ((d == KW'(1)) || (d == KW'(W - 1)));
    step_dir = DIR_LEFT;
    if (W == 2) begin
      // +1 and -1 coincide when W is 2; follow whatever direction is in use.
      step_dir = ref_dir_vld ? ref_dir : DIR_LEFT;
    end else if (d == KW'(1)) begin
      step_dir = DIR_LEFT;
    end else begin
      step_dir = DIR_RIGHT;
    end
  end

  function automatic logic [KW-1:0] amt_of(input logic [KW-1:0] kk, input dir_t dd);
    // Right-direction amount is (W - k) mod W, i.e. the two's complement in KW bits.
    return (dd == DIR_RIGHT) ? (~kk + KW'(1)) : kk;
  endfunction

  always_comb begin
    state_d    = state_q;
    prev_k_d   = prev_k_q;
    run_cnt_d  = run_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cand_vld_d = cand_vld_q;
    cand_dir_d = cand_dir_q;
    dir_d      = dir_q;
    amt_d      = amt_q;
    step_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dat_valid && good) begin
          prev_k_d   = k;
          run_cnt_d  = '0;
          miss_cnt_d = '0;
          cand_vld_d = 1'b0;
          state_d    = ACQ;
        end
      end

      ACQ: begin
        if (dat_valid) begin
          if (!good) begin
            state_d    = IDLE;
            run_cnt_d  = '0;
            cand_vld_d = 1'b0;
          end else if (hold) begin
            // Pattern unchanged: nothing to learn.
          end else if (step_vld && (!cand_vld_q || (step_dir == cand_dir_q))) begin
            cand_vld_d = 1'b1;
            cand_dir_d = step_dir;
            run_cnt_d  = run_cnt_q + RUN_W'(1);
            prev_k_d   = k;
            step_d     = 1'b1;
            // Amount tracks the candidate so it is already consistent at lock.
            amt_d      = amt_of(k, step_dir);
            if (int'(run_cnt_q) == LOCK_CNT - 1) begin
              state_d    = LOCKED;
              dir_d      = step_dir;
              miss_cnt_d = '0;
            end
          end else begin
            // Opposite step or non-adjacent jump: restart from this position.
            run_cnt_d  = '0;
            prev_k_d   = k;
            cand_vld_d = 1'b0;
          end
        end
      end

      LOCKED: begin
        if (dat_valid && !hold) begin
          if (step_vld && (step_dir == dir_q)) begin
            prev_k_d   = k;
            step_d     = 1'b1;
            miss_cnt_d = '0;
            amt_d      = amt_of(k, dir_q);
          end else begin
            // prev_k is kept so a later correct step is still recognised.
            err_d = 1'b1;
            if (int'(miss_cnt_q) == MISS_CNT - 1) begin
              state_d    = IDLE;
              miss_cnt_d = '0;
              run_cnt_d  = '0;
              cand_vld_d = 1'b0;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef ROTATION_DECODER_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == LOCKED) && !step_d) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d    = IDLE;
        err_d      = 1'b1;
        miss_cnt_d = '0;
        run_cnt_d  = '0;
        cand_vld_d = 1'b0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      prev_k_q   <= '0;
      run_cnt_q  <= '0;
      miss_cnt_q <= '0;
      cand_vld_q <= 1'b0;
      cand_dir_q <= DIR_LEFT;
      dir_q      <= DIR_LEFT;
      amt_q      <= '0;
      locked_q   <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      sym_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_k_q   <= prev_k_d;
      run_cnt_q  <= run_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      cand_vld_q <= cand_vld_d;
      cand_dir_q <= cand_dir_d;
      dir_q      <= dir_d;
      amt_q      <= amt_d;
      locked_q   <= locked_d;
      step_q     <= step_d;
      err_q      <= err_d;
      sym_q      <= sym_c;
    end
  end

`ifdef ROTATION_DECODER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign dir_out    = dir_q;
  assign amt_out    = amt_q;
  assign locked     = locked_q;
  assign step_pulse = step_q;
  assign err        = err_q;
  assign sym        = sym_q;

endmodule

// File: tb/tb_rotation_decoder.sv
// tb_rotation_decoder: table-driven check of rotation_decoder with an expected-value queue.
// Latency: expects outputs one clock after each driven sample.
// Backpressure: n/a.
module tb_rotation_decoder;

  localparam bit L = 1'b0;
  localparam bit H = 1'b1;

  logic       clk;
  logic       reset_n;
  logic [7:0] ref_in;
  logic [7:0] dat_in;
  logic       dat_valid;
  logic       dir_out;
  logic [2:0] amt_out;
  logic       locked;
  logic       step_pulse;
  logic       err;
  logic       sym;

  rotation_decoder #(
    .W(8), .LOCK_CNT(3), .MISS_CNT(2), .TIMEOUT_CYC(100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ref_in     (ref_in),
    .dat_in     (dat_in),
    .dat_valid  (dat_valid),
    .dir_out    (dir_out),
    .amt_out    (amt_out),
    .locked     (locked),
    .step_pulse (step_pulse),
    .err        (err),
    .sym        (sym)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = one pattern held for n cycles; pulses are expected only
  // after the first cycle, the other outputs after every cycle.
  typedef struct {
    logic [7:0] rf;
    logic [7:0] dt;
    logic       vld;
    int         n;
    logic       step;
    logic       er;
    logic       lck;
    logic       dir;
    logic [2:0] amt;
    logic       sy;
  } vec_t;

  typedef struct {
    int         idx;
    logic       step;
    logic       er;
    logic       lck;
    logic       dir;
    logic [2:0] amt;
    logic       sy;
  } exp_t;

  vec_t tbl[32];
  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [7:0] rf, input logic [7:0] dt, input logic vld,
                              input int n, input logic st, input logic er, input logic lk,
                              input logic dr, input logic [2:0] am, input logic sy);
    vec_t v;
    v.rf = rf; v.dt = dt; v.vld = vld; v.n = n;
    v.step = st; v.er = er; v.lck = lk; v.dir = dr; v.amt = am; v.sy = sy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic apply_row(input int idx);
    vec_t v;
    exp_t e;
    v = tbl[idx];
    for (int c = 0; c < v.n; c++) begin
      @(negedge clk);
      ref_in    = v.rf;
      dat_in    = v.dt;
      dat_valid = v.vld;
      e.idx  = idx;
      e.step = (c == 0) ? v.step : L;
      e.er   = (c == 0) ? v.er   : L;
      e.lck  = v.lck;
      e.dir  = v.dir;
      e.amt  = v.amt;
      e.sy   = v.sy;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_row(i);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare the DUT against the record driven one edge earlier.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("r%0d.step", e.idx),   32'(step_pulse), 32'(e.step));
        chk($sformatf("r%0d.err", e.idx),    32'(err),        32'(e.er));
        chk($sformatf("r%0d.locked", e.idx), 32'(locked),     32'(e.lck));
        chk($sformatf("r%0d.dir", e.idx),    32'(dir_out),    32'(e.dir));
        chk($sformatf("r%0d.amt", e.idx),    32'(amt_out),    32'(e.amt));
        chk($sformatf("r%0d.sym", e.idx),    32'(sym),        32'(e.sy));
      end
    end
  end

  initial begin
    bit seen;
    //              ref    dat    vld n  step err lck dir amt   sym
    // Left acquire from 0x01
    tbl[0]  = mk(8'h01, 8'h01, H, 5, L, L, L, L, 3'd0, L);
    tbl[1]  = mk(8'h01, 8'h02, H, 5, H, L, L, L, 3'd1, L);
    tbl[2]  = mk(8'h01, 8'h04, H, 5, H, L, L, L, 3'd2, L);
    tbl[3]  = mk(8'h01, 8'h08, H, 5, H, L, H, L, 3'd3, L);
    // Locked left, run up through the 7 -> 0 wrap
    tbl[4]  = mk(8'h01, 8'h10, H, 2, H, L, H, L, 3'd4, L);
    tbl[5]  = mk(8'h01, 8'h20, H, 2, H, L, H, L, 3'd5, L);
    tbl[6]  = mk(8'h01, 8'h40, H, 2, H, L, H, L, 3'd6, L);
    tbl[7]  = mk(8'h01, 8'h80, H, 3, H, L, H, L, 3'd7, L);
    tbl[8]  = mk(8'h01, 8'h01, H, 3, H, L, H, L, 3'd0, L);
    tbl[9]  = mk(8'h01, 8'h02, H, 3, H, L, H, L, 3'd1, L);
    // Not sampled while dat_valid is low
    tbl[10] = mk(8'h01, 8'h33, L, 3, L, L, H, L, 3'd1, L);
    // Two misses drop lock; amount holds
    tbl[11] = mk(8'h01, 8'h10, H, 1, L, H, H, L, 3'd1, L);
    tbl[12] = mk(8'h01, 8'h40, H, 1, L, H, L, L, 3'd1, L);
    // Right acquire from 0x03
    tbl[13] = mk(8'h03, 8'h03, H, 3, L, L, L, L, 3'd1, L);
    tbl[14] = mk(8'h03, 8'h81, H, 3, H, L, L, L, 3'd1, L);
    tbl[15] = mk(8'h03, 8'hC0, H, 3, H, L, L, L, 3'd2, L);
    tbl[16] = mk(8'h03, 8'h60, H, 3, H, L, H, H, 3'd3, L);
    // Locked right: step, wrong-way miss, recovery clears miss count
    tbl[17] = mk(8'h03, 8'h30, H, 1, H, L, H, H, 3'd4, L);
    tbl[18] = mk(8'h03, 8'h60, H, 1, L, H, H, H, 3'd4, L);
    tbl[19] = mk(8'h03, 8'h18, H, 2, H, L, H, H, 3'd5, L);
    tbl[20] = mk(8'h03, 8'h60, H, 1, L, H, H, H, 3'd5, L);
    tbl[21] = mk(8'h03, 8'h0C, H, 1, H, L, H, H, 3'd6, L);
    // Symmetric reference (after reset): never leaves IDLE
    tbl[22] = mk(8'h55, 8'h55, H, 2, L, L, L, L, 3'd0, H);
    tbl[23] = mk(8'h55, 8'hAA, H, 2, L, L, L, L, 3'd0, H);
    tbl[24] = mk(8'h55, 8'h55, H, 2, L, L, L, L, 3'd0, H);
    tbl[25] = mk(8'h55, 8'hAA, H, 2, L, L, L, L, 3'd0, H);
    // Opposite step restarts acquisition, then lock right
    tbl[26] = mk(8'h01, 8'h01, H, 2, L, L, L, L, 3'd0, L);
    tbl[27] = mk(8'h01, 8'h02, H, 1, H, L, L, L, 3'd1, L);
    tbl[28] = mk(8'h01, 8'h01, H, 2, L, L, L, L, 3'd1, L);
    tbl[29] = mk(8'h01, 8'h80, H, 1, H, L, L, L, 3'd1, L);
    tbl[30] = mk(8'h01, 8'h40, H, 1, H, L, L, L, 3'd2, L);
    tbl[31] = mk(8'h01, 8'h20, H, 2, H, L, H, H, 3'd3, L);

    reset_n   = 1'b0;
    ref_in    = 8'h00;
    dat_in    = 8'h00;
    dat_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.step",   32'(step_pulse), 32'd0);
    chk("rst.err",    32'(err),        32'd0);
    chk("rst.locked", 32'(locked),     32'd0);
    chk("rst.dir",    32'(dir_out),    32'd0);
    chk("rst.amt",    32'(amt_out),    32'd0);
    chk("rst.sym",    32'(sym),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_rows(0, 21);

    // Asynchronous reset in LOCKED: outputs clear without a clock edge.
    @(negedge clk);
    chk("pre_arst.locked", 32'(locked), 32'd1);
    #2;
    reset_n   = 1'b0;
    dat_valid = 1'b0;
    #1;
    chk("arst.locked", 32'(locked),     32'd0);
    chk("arst.dir",    32'(dir_out),    32'd0);
    chk("arst.amt",    32'(amt_out),    32'd0);
    chk("arst.step",   32'(step_pulse), 32'd0);
    chk("arst.err",    32'(err),        32'd0);
    chk("arst.sym",    32'(sym),        32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_rows(22, 31);

    // Static pattern while locked.
    seen = 1'b0;
`ifdef ROTATION_DECODER_TIMEOUT_EN
    for (int c = 0; c < 150 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (err) seen = 1'b1;
    end
    chk("tmo.err_seen", 32'(seen), 32'd1);
    chk("tmo.locked",   32'(locked), 32'd0);
`else
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (err || !locked) seen = 1'b1;
    end
    chk("static.no_drop", 32'(seen),   32'd0);
    chk("static.locked",  32'(locked), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
